// File: rtl/mem_wb_skid_if.sv
// MEM/WB stage bus: memory-stage enqueue side, write-back dequeue side, flush and status.
// master = pipeline environment, slave = the skid stage.
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              mem_r_en_in;
  logic              wb_en_in;
  logic [DEST_W-1:0] dest_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] mem_data_in;
  logic              out_valid;
  logic              out_ready;
  logic              mem_r_en_out;
  logic              wb_en_out;
  logic [DEST_W-1:0] dest_out;
  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] wb_value_out;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, mem_r_en_in, wb_en_in, dest_in, alu_res_in, mem_data_in, out_ready,
    input  in_ready, out_valid, mem_r_en_out, wb_en_out, dest_out, alu_res_out, mem_data_out,
           wb_value_out, occupancy
  );

  modport slave (
    input  flush, in_valid, mem_r_en_in, wb_en_in, dest_in, alu_res_in, mem_data_in, out_ready,
    output in_ready, out_valid, mem_r_en_out, wb_en_out, dest_out, alu_res_out, mem_data_out,
           wb_value_out, occupancy
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage as a 2-entry valid/ready skid buffer with flush and a
// pre-muxed write-back value; in_ready is registered so WB stalls never reach MEM combinationally.
module mem_wb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input logic          clk,
  input logic          rst,
  mem_wb_skid_if.slave bus
);
  typedef struct packed {
    logic              mem_r_en;
    logic              wb_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  logic   in_ready_q, in_ready_d;
  logic   enq, deq;

  assign in_e = {bus.mem_r_en_in, bus.wb_en_in, bus.dest_in, bus.alu_res_in, bus.mem_data_in};
  assign enq  = bus.in_valid & in_ready_q;
  assign deq  = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (enq) begin head_d = in_e; state_d = ONE; end
      ONE: begin
        if (enq && deq)  head_d = in_e;
        else if (enq)    begin skid_d = in_e; state_d = TWO; end
        else if (deq)    state_d = EMPTY;
      end
      TWO: if (deq) begin head_d = skid_q; state_d = ONE; end
      default: state_d = EMPTY;
    endcase
    // Flush only drops validity; stale data is harmless behind out_valid/wb_en gating.
    if (bus.flush) state_d = EMPTY;
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q != EMPTY);
  assign bus.mem_r_en_out = head_q.mem_r_en;
  assign bus.wb_en_out    = head_q.wb_en & (state_q != EMPTY);
  assign bus.dest_out     = head_q.dest;
  assign bus.alu_res_out  = head_q.alu_res;
  assign bus.mem_data_out = head_q.mem_data;
  assign bus.wb_value_out = head_q.mem_r_en ? head_q.mem_data : head_q.alu_res;
  assign bus.occupancy    = state_q;
endmodule
